// File: rtl/ctr_cascade_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : ctr_cascade_seq_if
// Description : Signal bundle between the cascade sequencer and its
//               environment. Carries the command handshake, the pacing
//               and abort controls, the cascade control and readback
//               lines, and the status outputs.
//               slave  : sequencer side (ctr_cascade_seq)
//               master : command source plus counter cascade
// Revision    : 1.0 - initial release
// ============================================================================
interface ctr_cascade_seq_if;
    logic        cmd_valid;    // command offered
    logic        cmd_ready;    // command accepted when valid && ready
    logic [1:0]  cmd_op;       // 00 LOAD, 01 UP, 10 DOWN, 11 reserved
    logic [11:0] cmd_arg;      // LOAD value or UP/DOWN step count
    logic        step_en;      // one cascade step per RUN cycle when high
    logic        abort;        // ends RUN early
    logic [11:0] ctr_d;        // cascade parallel-load data
    logic        ctr_sel2;     // cascade mode, upper bit
    logic        ctr_sel1;     // cascade mode, lower bit
    logic        ctr_nCryIn;   // active-low carry-in to low stage
    logic        ctr_nCryOut;  // active-low carry-out of high stage
    logic [11:0] ctr_q;        // cascade readback (status only)
    logic        busy;         // sequencer not idle
    logic        done;         // one-cycle completion pulse
    logic        ovf;          // sticky terminal-count wrap flag
    logic [11:0] steps_left;   // remaining steps of current/last UP/DOWN

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, step_en, abort,
               ctr_nCryOut, ctr_q,
        output cmd_ready, ctr_d, ctr_sel2, ctr_sel1, ctr_nCryIn,
               busy, done, ovf, steps_left
    );

    modport master (
        output cmd_valid, cmd_op, cmd_arg, step_en, abort,
               ctr_nCryOut, ctr_q,
        input  cmd_ready, ctr_d, ctr_sel2, ctr_sel1, ctr_nCryIn,
               busy, done, ovf, steps_left
    );
endinterface
`default_nettype wire

// File: rtl/ctr_cascade_seq.sv
`default_nettype none
// ============================================================================
// Module      : ctr_cascade_seq
// Description : Command sequencer for a three-stage 4-bit counter cascade.
//               Accepts LOAD / UP / DOWN commands, drives the cascade mode,
//               carry-in and load data, counts remaining steps and flags a
//               terminal-count wrap.
// Ports       : clk    - single clock, rising edge
//               reset  - synchronous, active-high
//               bus    - ctr_cascade_seq_if.slave (handshake, cascade, status)
// Revision    : 1.0 - initial release
// ============================================================================
module ctr_cascade_seq (
    input  logic              clk,
    input  logic              reset,
    ctr_cascade_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_UP     = 2'b01;
    localparam logic [1:0] OP_DOWN   = 2'b10;

    localparam logic [1:0] MODE_LOAD = 2'b00;
    localparam logic [1:0] MODE_INC  = 2'b01;
    localparam logic [1:0] MODE_DEC  = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    state_t      state_q, state_d;
    logic [1:0]  op_q,    op_d;
    logic [11:0] arg_q,   arg_d;
    logic [11:0] steps_q, steps_d;
    logic        ovf_q,   ovf_d;

    logic [1:0]  mode;
    logic        ready;
    logic        n_cry_in;
    logic        done_pulse;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_LOAD;
            arg_q   <= '0;
            steps_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            arg_q   <= arg_d;
            steps_q <= steps_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        arg_d      = arg_q;
        steps_d    = steps_q;
        ovf_d      = ovf_q;
        mode       = MODE_HOLD;
        ready      = 1'b0;
        n_cry_in   = 1'b1;
        done_pulse = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (bus.cmd_valid) begin
                    ovf_d = 1'b0;
                    op_d  = bus.cmd_op;
                    arg_d = bus.cmd_arg;
                    case (bus.cmd_op)
                        OP_LOAD: state_d = S_LOAD;
                        OP_UP, OP_DOWN: begin
                            steps_d = bus.cmd_arg;
                            state_d = (bus.cmd_arg != 12'd0) ? S_RUN : S_DONE;
                        end
                        default: state_d = S_DONE;
                    endcase
                end
            end

            S_LOAD: begin
                mode    = MODE_LOAD;
                state_d = S_DONE;
            end

            S_RUN: begin
                // Mode depends only on the registered op, so there is no
                // combinational path from ctr_nCryOut to the mode selects.
                mode     = (op_q == OP_UP) ? MODE_INC : MODE_DEC;
                n_cry_in = !(bus.step_en && !bus.abort);
                if (bus.abort) begin
                    state_d = S_DONE;
                end else if (bus.step_en) begin
                    if (steps_q != 12'd0) begin
                        steps_d = steps_q - 12'd1;
                    end
                    // Terminal count seen on a step edge: the cascade wraps
                    // on this edge, so the command ends here.
                    if (!bus.ctr_nCryOut) begin
                        ovf_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (steps_q <= 12'd1) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_DONE: begin
                done_pulse = 1'b1;
                state_d    = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Load data is always the registered argument; it only matters in
    // LOAD mode, and reset clears it to zero.
    assign bus.ctr_d      = arg_q;
    assign bus.ctr_sel2   = mode[1];
    assign bus.ctr_sel1   = mode[0];
    assign bus.ctr_nCryIn = n_cry_in;
    assign bus.cmd_ready  = ready;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = done_pulse;
    assign bus.ovf        = ovf_q;
    assign bus.steps_left = steps_q;

endmodule
`default_nettype wire

// File: tb/tb_ctr_cascade_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctr_cascade_seq
// Description : Self-checking bench for ctr_cascade_seq. Models a three-
//               stage 4-bit universal counter cascade as the load; expected
//               completion results are queued when a command is issued and
//               compared when the done pulse appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctr_cascade_seq;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    ctr_cascade_seq_if bus ();

    ctr_cascade_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- counter cascade model (not reset by the DUT) --------
    logic [11:0] cnt_q = 12'h000;
    logic [1:0]  w_sel;
    assign w_sel = {bus.ctr_sel2, bus.ctr_sel1};

    always @(posedge clk) begin
        case (w_sel)
            2'b00: cnt_q <= bus.ctr_d;
            2'b01: if (!bus.ctr_nCryIn) cnt_q <= cnt_q + 12'd1;
            2'b10: if (!bus.ctr_nCryIn) cnt_q <= cnt_q - 12'd1;
            default: cnt_q <= cnt_q;
        endcase
    end

    assign bus.ctr_q       = cnt_q;
    assign bus.ctr_nCryOut = !(!bus.ctr_nCryIn &&
                               ((w_sel == 2'b01 && cnt_q == 12'hFFF) ||
                                (w_sel == 2'b10 && cnt_q == 12'h000)));

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        string       tag;
        logic [11:0] q;
        logic [11:0] steps;
        logic        ovf;
    } exp_t;

    exp_t sb[$];

    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (sb.size() == 0) begin
                check_eq("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq({e.tag, "_ctr_q"}, 32'(bus.ctr_q), 32'(e.q));
                check_eq({e.tag, "_steps"}, 32'(bus.steps_left), 32'(e.steps));
                check_eq({e.tag, "_ovf"},   32'(bus.ovf), 32'(e.ovf));
            end
        end
    end

    // Issue one command from IDLE and follow it to completion.
    // pat bit i = step_en in the i-th cycle after acceptance.
    task automatic run_cmd(input string tag, input logic [1:0] op,
                           input logic [11:0] arg, input logic [15:0] pat,
                           input int abort_at, input bit abort_hold,
                           input int exp_cyc, input logic [11:0] eq,
                           input logic [11:0] es, input logic eo);
        exp_t e;
        int   cyc;
        e.tag = tag; e.q = eq; e.steps = es; e.ovf = eo;
        sb.push_back(e);

        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_arg   = arg;
        bus.abort     = abort_hold;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        check_eq({tag, "_rdy_low"}, 32'(bus.cmd_ready), 32'd0);

        cyc = 0;
        while (!bus.done && cyc < 40) begin
            bus.step_en = (cyc < 16) ? pat[cyc] : 1'b1;
            bus.abort   = abort_hold || (cyc == abort_at);
            @(posedge clk); #1;
            cyc++;
        end
        bus.step_en = 1'b0;
        bus.abort   = 1'b0;
        check_eq({tag, "_done"}, 32'(bus.done), 32'd1);
        check_eq({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));

        @(posedge clk); #1;
        check_eq({tag, "_idle"},
                 32'({bus.done, bus.cmd_ready, bus.busy}), 32'b010);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_arg   = 12'h000;
        bus.step_en   = 1'b0;
        bus.abort     = 1'b0;

        // Reset state
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_mode",   32'(w_sel), 32'd3);
        check_eq("rst_ncry",   32'(bus.ctr_nCryIn), 32'd1);
        check_eq("rst_ctr_d",  32'(bus.ctr_d), 32'h000);
        check_eq("rst_status", 32'({bus.cmd_ready, bus.busy, bus.done, bus.ovf}),
                 32'b1000);
        check_eq("rst_steps",  32'(bus.steps_left), 32'h000);
        reset = 1'b0;
        @(posedge clk); #1;

        run_cmd("load123", 2'b00, 12'h123, 16'hFFFF, -1, 1'b0, 1, 12'h123, 12'h000, 1'b0);
        run_cmd("up5",     2'b01, 12'd5,   16'hFFFF, -1, 1'b0, 5, 12'h128, 12'h000, 1'b0);
        run_cmd("load001", 2'b00, 12'h001, 16'hFFFF, -1, 1'b0, 1, 12'h001, 12'h000, 1'b0);
        run_cmd("down3",   2'b10, 12'd3,   16'hFFFF, -1, 1'b0, 2, 12'hFFF, 12'h001, 1'b1);
        check_eq("ovf_sticky", 32'(bus.ovf), 32'd1);
        // abort held through a LOAD is ignored; acceptance clears ovf
        run_cmd("load010", 2'b00, 12'h010, 16'hFFFF, -1, 1'b1, 1, 12'h010, 12'h001, 1'b0);
        run_cmd("up4pat",  2'b01, 12'd4,   16'hFFD9, -1, 1'b0, 7, 12'h014, 12'h000, 1'b0);
        run_cmd("load000", 2'b00, 12'h000, 16'hFFFF, -1, 1'b0, 1, 12'h000, 12'h000, 1'b0);
        run_cmd("up10abt", 2'b01, 12'd10,  16'hFFFF,  2, 1'b0, 3, 12'h002, 12'h008, 1'b0);
        run_cmd("up0",     2'b01, 12'd0,   16'hFFFF, -1, 1'b0, 0, 12'h002, 12'h000, 1'b0);
        run_cmd("rsvd",    2'b11, 12'h555, 16'hFFFF, -1, 1'b0, 0, 12'h002, 12'h000, 1'b0);

        // Reset during the third RUN cycle of UP 10 (starting from 002)
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b01;
        bus.cmd_arg   = 12'd10;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.step_en   = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        bus.step_en   = 1'b0;
        reset         = 1'b1;
        @(posedge clk); #1;
        reset         = 1'b0;
        check_eq("rrun_mode",   32'(w_sel), 32'd3);
        check_eq("rrun_ncry",   32'(bus.ctr_nCryIn), 32'd1);
        check_eq("rrun_status", 32'({bus.cmd_ready, bus.busy, bus.done, bus.ovf}),
                 32'b1000);
        check_eq("rrun_steps",  32'(bus.steps_left), 32'h000);
        check_eq("rrun_ctr_q",  32'(bus.ctr_q), 32'h004);
        repeat (3) begin
            @(posedge clk); #1;
            check_eq("rrun_no_done", 32'(bus.done), 32'd0);
        end
        check_eq("rrun_ctr_hold", 32'(bus.ctr_q), 32'h004);
        check_eq("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ctr_cascade_seq.md
CTR_CASCADE_SEQ -- requirements
Module: ctr_cascade_seq

Interface
REQ-001 clk  in  1  single clock; all state changes on its rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 cmd_valid  in  1  command offered.
REQ-004 cmd_ready  out  1  command accepted at an edge where cmd_valid&&cmd_ready.
REQ-005 cmd_op  in  2  00 LOAD, 01 UP, 10 DOWN, 11 reserved (no-op).
REQ-006 cmd_arg  in  12  LOAD: value to load; UP/DOWN: step count N.
REQ-007 step_en  in  1  pacing; one counter step per RUN cycle with step_en=1.
REQ-008 abort  in  1  terminate RUN early.
REQ-009 ctr_d  out  12  parallel load data to the three-stage 4-bit counter cascade; bit 0 is the LSB.
REQ-010 ctr_sel2, ctr_sel1  out  1 each  cascade mode: 00 LOAD, 01 INC, 10 DEC, 11 HOLD.
REQ-011 ctr_nCryIn  out  1  active-low carry-in to the low stage.
REQ-012 ctr_nCryOut  in  1  active-low carry-out of the high stage; low = terminal count (FFF on INC, 000 on DEC).
REQ-013 ctr_q  in  12  cascade readback; status only, no control use.
REQ-014 busy  out  1  state != IDLE.
REQ-015 done  out  1  one-cycle pulse on command completion.
REQ-016 ovf  out  1  terminal-count wrap seen; sticky until next accepted command.
REQ-017 steps_left  out  12  remaining steps of the current or last UP/DOWN command.

Function
REQ-018 States: IDLE, LOAD, RUN, DONE.
REQ-019 IDLE: cmd_ready=1, mode HOLD, ctr_nCryIn=1.
REQ-020 Acceptance in IDLE clears ovf and registers cmd_op/cmd_arg.
  - LOAD -> LOAD.
  - UP/DOWN with N!=0 -> RUN, steps_left=N.
  - UP/DOWN with N=0 -> DONE, steps_left=0.
  - Reserved op -> DONE.
REQ-021 LOAD state lasts exactly one cycle.
  - Mode 00, ctr_d = registered arg, ctr_nCryIn=1.
  - Next state DONE.
  - Latency: accept at edge k, cascade loads at edge k+1, done high in cycle k+1..k+2, cmd_ready high again after edge k+2.
REQ-022 RUN drives mode INC for UP and DEC for DOWN.
  - ctr_nCryIn = !(step_en && !abort), combinational from registered state and inputs.
  - No path from ctr_nCryOut to ctr_sel*.
REQ-023 RUN step edge (step_en=1, abort=0): steps_left decrements by 1.
  - If ctr_nCryOut=0 in that cycle: set ovf, next state DONE (the cascade wraps on that edge).
  - Else if steps_left was 1: next state DONE.
  - Else: stay in RUN.
REQ-024 RUN with step_en=0, abort=0: no step; state and steps_left hold.
REQ-025 RUN with abort=1: no step that cycle; next state DONE; steps_left and ovf hold. abort outside RUN is ignored.
REQ-026 DONE lasts one cycle: done=1, cmd_ready=0, mode HOLD, ctr_nCryIn=1; next state IDLE.
REQ-027 cmd_ready=0 in LOAD, RUN and DONE; cmd_valid is ignored there.
REQ-028 steps_left arithmetic is 12-bit unsigned and never decrements below 0; max N = 4095.

Reset
REQ-029 reset=1 at an edge forces the following outputs from the next cycle, overriding all other inputs:
  - State IDLE.
  - ctr_sel2/ctr_sel1=11, ctr_nCryIn=1, ctr_d=000.
  - cmd_ready=1; busy, done, ovf = 0; steps_left=000.
REQ-030 Reset mid-LOAD or mid-RUN abandons the command with no done pulse; cascade contents are not altered by this block.

Verification (bench uses three cascaded 4-bit universal counter stages as the load)
REQ-031 LOAD arg=123 -> ctr_q=123 after edge k+1, one done pulse, ovf=0.
REQ-032 Then UP N=5, step_en=1 -> exactly 5 RUN cycles, ctr_q=128, steps_left=000, done.
REQ-033 LOAD 001, DOWN N=3 -> steps 001->000->FFF (wrap at terminal), ovf=1, steps_left=001, done.
REQ-034 LOAD 010, UP N=4, step_en pattern 1,0,0,1,1,0,1 -> ctr_q=014, done in cycle after 7th RUN cycle.
REQ-035 UP N=10 from 000, abort after 2 steps -> ctr_q=002, steps_left=008, ovf=0, done; then UP N=0 -> immediate done, ctr_q unchanged.
REQ-036 reset asserted in 3rd RUN cycle -> next cycle mode=11, ctr_nCryIn=1, cmd_ready=1, no done, ctr_q holds.
